// File: rtl/log_motion.sv
// log_motion: scrolling log positions for six lanes of a frogger-style playfield.
// Each lane owns a frame divider. Every log on a lane moves 1 px when that lane's
// divider expires. Positions wrap around a virtual track of TRACK_SPAN pixels.
module log_motion #(
   parameter int TRACK_SPAN      = 640,
   parameter int LANE0_LEN       = 64,
   parameter int LANE1_LEN       = 96,
   parameter int LANE2_LEN       = 64,
   parameter int LANE3_LEN       = 96,
   parameter int LANE4_LEN       = 64,
   parameter int LANE5_LEN       = 96,
   parameter int LANE0_DIR       = 0,
   parameter int LANE1_DIR       = 1,
   parameter int LANE2_DIR       = 0,
   parameter int LANE3_DIR       = 1,
   parameter int LANE4_DIR       = 0,
   parameter int LANE5_DIR       = 1,
   parameter int LANE0_PERIOD    = 4,
   parameter int LANE1_PERIOD    = 3,
   parameter int LANE2_PERIOD    = 2,
   parameter int LANE3_PERIOD    = 4,
   parameter int LANE4_PERIOD    = 3,
   parameter int LANE5_PERIOD    = 2,
   parameter int LANE0_LOG0_INIT = 96,
   parameter int LANE0_LOG1_INIT = 256,
   parameter int LANE0_LOG2_INIT = 416,
   parameter int LANE1_LOG0_INIT = 96,
   parameter int LANE1_LOG1_INIT = 320,
   parameter int LANE2_LOG0_INIT = 96,
   parameter int LANE2_LOG1_INIT = 320,
   parameter int LANE3_LOG0_INIT = 96,
   parameter int LANE3_LOG1_INIT = 320,
   parameter int LANE4_LOG0_INIT = 96,
   parameter int LANE4_LOG1_INIT = 320,
   parameter int LANE5_LOG0_INIT = 96,
   parameter int LANE5_LOG1_INIT = 320
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       pause,
   input  logic       restart,
   input  logic [1:0] speed_level,
   output logic [9:0] lane0_log0_x,
   output logic [9:0] lane0_log1_x,
   output logic [9:0] lane0_log2_x,
   output logic [9:0] lane1_log0_x,
   output logic [9:0] lane1_log1_x,
   output logic [9:0] lane2_log0_x,
   output logic [9:0] lane2_log1_x,
   output logic [9:0] lane3_log0_x,
   output logic [9:0] lane3_log1_x,
   output logic [9:0] lane4_log0_x,
   output logic [9:0] lane4_log1_x,
   output logic [9:0] lane5_log0_x,
   output logic [9:0] lane5_log1_x,
   output logic [9:0] lane0_loglength,
   output logic [9:0] lane1_loglength,
   output logic [9:0] lane2_loglength,
   output logic [9:0] lane3_loglength,
   output logic [9:0] lane4_loglength,
   output logic [9:0] lane5_loglength,
   output logic [5:0] lane_step,
   output logic [5:0] lane_dir
);

   localparam int NLANE = 6;
   localparam int NLOG  = 13;

   // Log i belongs to lane LOG_LANE[i]; lane 0 carries three logs, the rest two.
   localparam int LOG_LANE [NLOG] = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
   localparam int LOG_INIT [NLOG] = '{LANE0_LOG0_INIT, LANE0_LOG1_INIT, LANE0_LOG2_INIT,
                                      LANE1_LOG0_INIT, LANE1_LOG1_INIT,
                                      LANE2_LOG0_INIT, LANE2_LOG1_INIT,
                                      LANE3_LOG0_INIT, LANE3_LOG1_INIT,
                                      LANE4_LOG0_INIT, LANE4_LOG1_INIT,
                                      LANE5_LOG0_INIT, LANE5_LOG1_INIT};
   localparam int PERIOD [NLANE] = '{LANE0_PERIOD, LANE1_PERIOD, LANE2_PERIOD,
                                     LANE3_PERIOD, LANE4_PERIOD, LANE5_PERIOD};
   localparam int DIR    [NLANE] = '{LANE0_DIR, LANE1_DIR, LANE2_DIR,
                                     LANE3_DIR, LANE4_DIR, LANE5_DIR};

   localparam logic [9:0] SPAN_M1 = 10'(TRACK_SPAN - 1);

   logic [9:0] x_q   [NLOG];
   logic [9:0] x_d   [NLOG];
   logic [3:0] div_q [NLANE];
   logic [3:0] div_d [NLANE];
   logic [5:0] step_q;
   logic [5:0] step_d;
   logic       advance;

   // One pixel in the lane's direction, wrapping by compare rather than modulo.
   function automatic logic [9:0] step_pos(input logic [9:0] x, input logic right);
      logic [9:0] r;
      if (right) r = (x == SPAN_M1) ? 10'd0 : x + 10'd1;
      else       r = (x == 10'd0)   ? SPAN_M1 : x - 10'd1;
      return r;
   endfunction

   // Speed-up shortens the period but never below one tick per pixel.
   function automatic logic [3:0] per_eff(input int period, input logic [1:0] spd);
      logic [3:0] sh;
      sh = 4'(period) >> spd;
      return (sh == 4'd0) ? 4'd1 : sh;
   endfunction

   // Next-state: restart reloads, a qualifying tick counts down or steps, otherwise hold.
   always_comb begin
      advance = frame_tick & ~pause & ~restart;
      step_d  = '0;
      for (int k = 0; k < NLANE; k++) begin
         div_d[k] = div_q[k];
         if (restart) begin
            div_d[k] = 4'(PERIOD[k] - 1);
         end else if (advance) begin
            if (div_q[k] == 4'd0) begin
               step_d[k] = 1'b1;
               div_d[k]  = per_eff(PERIOD[k], speed_level) - 4'd1;
            end else begin
               div_d[k]  = div_q[k] - 4'd1;
            end
         end
      end
      for (int i = 0; i < NLOG; i++) begin
         x_d[i] = x_q[i];
         if (restart)
            x_d[i] = 10'(LOG_INIT[i]);
         else if (step_d[LOG_LANE[i]])
            x_d[i] = step_pos(x_q[i], DIR[LOG_LANE[i]] != 0);
      end
   end

   // State registers; reset forces the start-of-game layout immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NLOG; i++)  x_q[i]   <= 10'(LOG_INIT[i]);
         for (int k = 0; k < NLANE; k++) div_q[k] <= 4'(PERIOD[k] - 1);
         step_q <= '0;
      end else begin
         for (int i = 0; i < NLOG; i++)  x_q[i]   <= x_d[i];
         for (int k = 0; k < NLANE; k++) div_q[k] <= div_d[k];
         step_q <= step_d;
      end
   end

   assign lane0_log0_x = x_q[0];
   assign lane0_log1_x = x_q[1];
   assign lane0_log2_x = x_q[2];
   assign lane1_log0_x = x_q[3];
   assign lane1_log1_x = x_q[4];
   assign lane2_log0_x = x_q[5];
   assign lane2_log1_x = x_q[6];
   assign lane3_log0_x = x_q[7];
   assign lane3_log1_x = x_q[8];
   assign lane4_log0_x = x_q[9];
   assign lane4_log1_x = x_q[10];
   assign lane5_log0_x = x_q[11];
   assign lane5_log1_x = x_q[12];

   assign lane_step = step_q;

   assign lane0_loglength = 10'(LANE0_LEN);
   assign lane1_loglength = 10'(LANE1_LEN);
   assign lane2_loglength = 10'(LANE2_LEN);
   assign lane3_loglength = 10'(LANE3_LEN);
   assign lane4_loglength = 10'(LANE4_LEN);
   assign lane5_loglength = 10'(LANE5_LEN);

   assign lane_dir = {LANE5_DIR != 0, LANE4_DIR != 0, LANE3_DIR != 0,
                      LANE2_DIR != 0, LANE1_DIR != 0, LANE0_DIR != 0};

endmodule

// File: tb/tb_log_motion.sv
// Testbench for log_motion: directed frame-tick sequences, a tick-countdown
// reference model compared every cycle, and hand-computed position checkpoints.
module tb_log_motion;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       frame_tick = 1'b0;
   logic       pause = 1'b0;
   logic       restart = 1'b0;
   logic [1:0] speed_level = 2'd0;
   logic [9:0] l0g0, l0g1, l0g2, l1g0, l1g1, l2g0, l2g1, l3g0, l3g1, l4g0, l4g1, l5g0, l5g1;
   logic [9:0] len0, len1, len2, len3, len4, len5;
   logic [5:0] lane_step, lane_dir;
   logic [9:0] dx [13];

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   log_motion dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .pause(pause),
      .restart(restart), .speed_level(speed_level),
      .lane0_log0_x(l0g0), .lane0_log1_x(l0g1), .lane0_log2_x(l0g2),
      .lane1_log0_x(l1g0), .lane1_log1_x(l1g1),
      .lane2_log0_x(l2g0), .lane2_log1_x(l2g1),
      .lane3_log0_x(l3g0), .lane3_log1_x(l3g1),
      .lane4_log0_x(l4g0), .lane4_log1_x(l4g1),
      .lane5_log0_x(l5g0), .lane5_log1_x(l5g1),
      .lane0_loglength(len0), .lane1_loglength(len1), .lane2_loglength(len2),
      .lane3_loglength(len3), .lane4_loglength(len4), .lane5_loglength(len5),
      .lane_step(lane_step), .lane_dir(lane_dir)
   );

   assign dx[0] = l0g0;  assign dx[1] = l0g1;  assign dx[2] = l0g2;
   assign dx[3] = l1g0;  assign dx[4] = l1g1;  assign dx[5] = l2g0;
   assign dx[6] = l2g1;  assign dx[7] = l3g0;  assign dx[8] = l3g1;
   assign dx[9] = l4g0;  assign dx[10] = l4g1; assign dx[11] = l5g0;
   assign dx[12] = l5g1;

   always #5 clk = ~clk;

   // Reference model: each lane waits a number of qualifying ticks, then moves.
   localparam int M_LANE [13] = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
   localparam int M_INIT [13] = '{96, 256, 416, 96, 320, 96, 320, 96, 320, 96, 320, 96, 320};
   localparam int M_PER  [6]  = '{4, 3, 2, 4, 3, 2};
   localparam int M_DIR  [6]  = '{0, 1, 0, 1, 0, 1};

   int         mx [13];
   int         ticks_left [6];
   logic [5:0] mstep;

   always @(posedge clk or posedge reset) begin
      if (reset || restart) begin
         for (int i = 0; i < 13; i++) mx[i] = M_INIT[i];
         for (int k = 0; k < 6; k++)  ticks_left[k] = M_PER[k];
         mstep = '0;
      end else if (frame_tick && !pause) begin
         for (int k = 0; k < 6; k++) begin
            ticks_left[k] = ticks_left[k] - 1;
            mstep[k] = (ticks_left[k] == 0);
            if (ticks_left[k] == 0) begin
               ticks_left[k] = (M_PER[k] >> speed_level) > 0 ? (M_PER[k] >> speed_level) : 1;
               for (int i = 0; i < 13; i++)
                  if (M_LANE[i] == k)
                     mx[i] = M_DIR[k] ? (mx[i] + 1) % 640 : (mx[i] + 639) % 640;
            end
         end
      end else begin
         mstep = '0;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_on) begin
         for (int i = 0; i < 13; i++) chk($sformatf("model_x%0d", i), int'(dx[i]), mx[i]);
         chk("model_lane_step", int'(lane_step), int'(mstep));
      end
   end

   task automatic cyc(input logic ft);
      @(negedge clk);
      frame_tick = ft;
   endtask

   task automatic tick();
      cyc(1'b1);
      cyc(1'b0);
   endtask

   initial begin
      #2 reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_l0g0", l0g0, 96);
      chk("rst_l0g1", l0g1, 256);
      chk("rst_l0g2", l0g2, 416);
      chk("rst_l1g1", l1g1, 320);
      chk("rst_step", lane_step, 0);
      chk("dir_const", lane_dir, 6'b101010);
      chk("len0", len0, 64);
      chk("len1", len1, 96);
      chk("len5", len5, 96);
      reset = 1'b0;
      chk_on = 1'b1;

      // Four ticks at base speed.
      for (int t = 1; t <= 3; t++) begin
         tick();
         chk($sformatf("t%0d_l0g0", t), l0g0, 96);
         chk($sformatf("t%0d_step0", t), lane_step[0], 0);
      end
      tick();
      chk("t4_l0g0", l0g0, 95);
      chk("t4_l0g1", l0g1, 255);
      chk("t4_l0g2", l0g2, 415);
      chk("t4_l2g0", l2g0, 94);
      chk("t4_l1g0", l1g0, 97);
      chk("t4_step", lane_step, 6'b101101);
      cyc(1'b0);
      chk("t4_step_one_cycle", lane_step, 0);

      // Pause freezes everything across ten ticks.
      pause = 1'b1;
      repeat (10) begin
         tick();
         chk("pause_step", lane_step, 0);
      end
      chk("pause_l0g0", l0g0, 95);
      chk("pause_l1g0", l1g0, 97);
      pause = 1'b0;

      // Resume from held counts: ticks 5..8.
      repeat (4) tick();
      chk("t8_l0g0", l0g0, 94);
      chk("t8_l1g0", l1g0, 98);

      // Speed 2: lane 0's in-flight count finishes at the old period first.
      speed_level = 2'd2;
      repeat (3) tick();
      chk("t11_l0g0", l0g0, 94);
      tick();
      chk("t12_l0g0", l0g0, 93);
      tick();
      chk("t13_l0g0", l0g0, 92);
      tick();
      chk("t14_l0g0", l0g0, 91);
      chk("t14_step0", lane_step[0], 1);

      // Restart coincident with a tick while lane 0 is due to step.
      @(negedge clk);
      restart = 1'b1;
      frame_tick = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      frame_tick = 1'b0;
      speed_level = 2'd3;
      chk("rs_l0g0", l0g0, 96);
      chk("rs_l0g2", l0g2, 416);
      chk("rs_l1g1", l1g1, 320);
      chk("rs_step", lane_step, 0);

      // Held frame_tick at full speed, through both wrap directions.
      repeat (99) cyc(1'b1);
      cyc(1'b0);
      chk("wrapL_l0g0_at0", l0g0, 0);
      tick();
      chk("wrapL_l0g0", l0g0, 639);
      chk("wrapL_l0g1", l0g1, 159);
      repeat (445) cyc(1'b1);
      cyc(1'b0);
      chk("wrapR_l1g0_at639", l1g0, 639);
      chk("wrapR_l1g1_pre", l1g1, 223);
      tick();
      chk("wrapR_l1g0", l1g0, 0);
      chk("wrapR_l1g1", l1g1, 224);
      chk("wrapR_step1", lane_step[1], 1);

      // Mid-count asynchronous reset, then the first move on the PERIOD-th tick.
      speed_level = 2'd0;
      tick();
      tick();
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("arst_l0g0", l0g0, 96);
      chk("arst_l0g2", l0g2, 416);
      chk("arst_l1g0", l1g0, 96);
      chk("arst_l5g1", l5g1, 320);
      chk("arst_step", lane_step, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         tick();
         chk("post_rst_l0g0_hold", l0g0, 96);
      end
      tick();
      chk("post_rst_l0g0", l0g0, 95);
      chk("post_rst_step0", lane_step[0], 1);

      cyc(1'b0);
      chk_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
